midi_message_encoder: RTL and testbench

// - Consumes one note event at a time from the upstream per-channel MIDI status buffer (valid-pulse / ack handshake).
// - Encodes each event into a 3-byte MIDI Note On / Note Off message.
// - Streams the bytes to a UART transmitter over a valid/ready byte interface.
// - Pulses in_ack once the whole message has been handed to the transmitter, releasing the buffer for its next event.
//

---
 rtl/midi_message_encoder_if.sv | 24 ++
 rtl/midi_message_encoder.sv | 114 +++++++++++
 tb/tb_midi_message_encoder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_message_encoder_if.sv
// Note-event handshake and UART byte stream bundle for midi_message_encoder.
// master = event source / byte sink, slave = the encoder.
interface midi_message_encoder_if;
  logic       note_on_in;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic [3:0] channel_in;
  logic       in_valid;
  logic       in_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  modport master (
    output note_on_in, note_in, octave_in, channel_in, in_valid, tx_ready,
    input  in_ack, tx_data, tx_valid, busy
  );

  modport slave (
    input  note_on_in, note_in, octave_in, channel_in, in_valid, tx_ready,
    output in_ack, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/midi_message_encoder.sv
// Encodes one note event into a 3-byte MIDI Note On/Off message on a valid/ready byte stream.
// Define MIDI_RUNNING_STATUS_EN to omit a status byte equal to the last one sent.
module midi_message_encoder #(
  parameter logic [6:0] BASE_NOTE    = 7'd48,
  parameter logic [6:0] VELOCITY_ON  = 7'd100,
  parameter logic [6:0] VELOCITY_OFF = 7'd64
) (
  input  logic                   clk,
  input  logic                   reset,
  midi_message_encoder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, STATUS, DATA1, DATA2, DONE} state_t;

  state_t     state;
  logic       note_on_r;
  logic [6:0] note_num_r;
  logic [7:0] status_byte;
  logic [6:0] note_num;
  logic       xfer;
  logic       skip_status;

  // Sum fits in 8 bits for any legal parameter; the top bit is dropped, no clamping.
  function automatic logic [6:0] note_number(input logic [1:0] octave, input logic [3:0] note);
    logic [7:0] sum;
    sum = {1'b0, BASE_NOTE} + (8'd12 * {6'd0, octave}) + {4'd0, note};
    return sum[6:0];
  endfunction

  function automatic logic [7:0] status_of(input logic note_on, input logic [3:0] channel);
    return {3'b100, note_on, channel};
  endfunction

  assign status_byte = status_of(bus.note_on_in, bus.channel_in);
  assign note_num    = note_number(bus.octave_in, bus.note_in);
  assign xfer        = bus.tx_valid && bus.tx_ready;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       last_status_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_status_valid <= 1'b0;
    end else if (state == STATUS && xfer) begin
      last_status       <= bus.tx_data;
      last_status_valid <= 1'b1;
    end
  end

  assign skip_status = last_status_valid && (status_byte == last_status);
`else
  assign skip_status = 1'b0;
`endif

  // tx_data/tx_valid only change on a transfer, so they hold steady under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.in_ack   <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.in_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            note_on_r    <= bus.note_on_in;
            note_num_r   <= note_num;
            bus.tx_valid <= 1'b1;
            bus.busy     <= 1'b1;
            if (skip_status) begin
              bus.tx_data <= {1'b0, note_num};
              state       <= DATA1;
            end else begin
              bus.tx_data <= status_byte;
              state       <= STATUS;
            end
          end
        end
        STATUS: begin
          if (xfer) begin
            bus.tx_data <= {1'b0, note_num_r};
            state       <= DATA1;
          end
        end
        DATA1: begin
          if (xfer) begin
            bus.tx_data <= {1'b0, note_on_r ? VELOCITY_ON : VELOCITY_OFF};
            state       <= DATA2;
          end
        end
        DATA2: begin
          if (xfer) begin
            bus.tx_valid <= 1'b0;
            bus.in_ack   <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.tx_valid <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_message_encoder.sv
// Randomised and directed bench for midi_message_encoder against a byte-queue reference model.
// Honours MIDI_RUNNING_STATUS_EN the same way the design does.
module tb_midi_message_encoder;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  midi_message_encoder_if bus ();

  midi_message_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         ack_cnt = 0;
  logic [7:0] act_q[$];
  logic [7:0] exp_q[$];
  int         rd = 0;
  bit         rs_valid = 1'b0;
  int         rs_last  = 0;

  always @(negedge clk) begin
    if (!reset && bus.tx_valid && bus.tx_ready) act_q.push_back(bus.tx_data);
    if (bus.in_ack) ack_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Length in the top byte, then up to seven bytes in arrival order.
  function automatic logic [63:0] pack(input logic [7:0] q[$], input int from);
    logic [63:0] r;
    int len;
    r = '0;
    len = q.size() - from;
    r[63:56] = 8'(len);
    for (int i = 0; i < len && i < 7; i++) r[55-8*i -: 8] = q[from+i];
    return r;
  endfunction

  task automatic model(input bit on, input int n, input int o, input int ch);
    int st;
    int num;
    st  = (on ? 144 : 128) + ch;
    num = (48 + 12*o + n) % 128;
    if (!(RS && rs_valid && st == rs_last)) exp_q.push_back(8'(st));
    rs_valid = 1'b1;
    rs_last  = st;
    exp_q.push_back(8'(num));
    exp_q.push_back(on ? 8'd100 : 8'd64);
  endtask

  task automatic send(input bit on, input logic [3:0] n, input logic [1:0] o, input logic [3:0] ch);
    bus.note_on_in = on;
    bus.note_in    = n;
    bus.octave_in  = o;
    bus.channel_in = ch;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.note_on_in = 1'($urandom);
    bus.note_in    = 4'($urandom);
    bus.octave_in  = 2'($urandom);
    bus.channel_in = 4'($urandom);
  endtask

  task automatic wait_ack(input int target, input bit rnd, output bit ok);
    for (int c = 0; c < 300 && ack_cnt < target; c++) begin
      @(posedge clk); #1;
      if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
    end
    bus.tx_ready = 1'b1;
    ok = (ack_cnt >= target);
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rs_valid = 1'b0;
    rd = act_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    n_cmp++; if (bus.in_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack: got %b want 0", bus.in_ack); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [7:0] eb [3];
    int base;
    eb = '{8'h93, 8'h4D, 8'h64};
    base = ack_cnt;
    send(1'b1, 4'd5, 2'd2, 4'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.tx_valid, bus.tx_data, bus.in_ack} !== {1'b1, eb[i], 1'b0}) begin
        n_fail++;
        $display("FAIL latency_byte%0d: got valid=%b data=%h ack=%b want valid=1 data=%h ack=0",
                 i, bus.tx_valid, bus.tx_data, bus.in_ack, eb[i]);
      end
    end
    @(negedge clk);
    n_cmp++; if ({bus.tx_valid, bus.in_ack} !== 2'b01) begin n_fail++; $display("FAIL latency_ack: got valid=%b ack=%b want valid=0 ack=1", bus.tx_valid, bus.in_ack); end
    @(negedge clk);
    n_cmp++; if ({bus.in_ack, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL latency_idle: got ack=%b busy=%b want 0 0", bus.in_ack, bus.busy); end
    @(posedge clk); #1;
    n_cmp++; if (ack_cnt !== base + 1) begin n_fail++; $display("FAIL latency_ack_count: got %0d want %0d", ack_cnt - base, 1); end
    n_cmp++; if (pack(act_q, rd) !== 64'h03_934D64_00000000) begin n_fail++; $display("FAIL latency_stream: got %h want %h", pack(act_q, rd), 64'h03_934D64_00000000); end
    rd = act_q.size();
    rs_valid = 1'b1; rs_last = 8'h93;
  endtask

  task automatic test_vectors();
    logic [3:0]  ch [2];
    logic [3:0]  nt [2];
    logic [1:0]  oc [2];
    bit          on [2];
    logic [63:0] want [2];
    int base;
    bit ok;
    ch = '{4'd0, 4'd15}; nt = '{4'd0, 4'd15}; oc = '{2'd0, 2'd3}; on = '{1'b0, 1'b1};
    want = '{64'h03_803040_00000000, 64'h03_9F6364_00000000};
    for (int k = 0; k < 2; k++) begin
      base = ack_cnt;
      send(on[k], nt[k], oc[k], ch[k]);
      wait_ack(base + 1, 1'b0, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL vector%0d_timeout: got no in_ack want in_ack", k); end
      repeat (3) @(posedge clk); #1;
      n_cmp++; if (ack_cnt !== base + 1) begin n_fail++; $display("FAIL vector%0d_ack_count: got %0d want 1", k, ack_cnt - base); end
      n_cmp++; if (pack(act_q, rd) !== want[k]) begin n_fail++; $display("FAIL vector%0d_stream: got %h want %h", k, pack(act_q, rd), want[k]); end
      rd = act_q.size();
      rs_valid = 1'b1; rs_last = {3'b100, on[k], ch[k]};
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    apply_reset();
    base = ack_cnt;
    send(1'b1, 4'd5, 2'd2, 4'd3);
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.tx_valid, bus.tx_data, bus.in_ack} !== {1'b1, 8'h4D, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: got valid=%b data=%h ack=%b want valid=1 data=4d ack=0",
                 i, bus.tx_valid, bus.tx_data, bus.in_ack);
      end
      @(posedge clk); #1;
    end
    bus.tx_ready = 1'b1;
    wait_ack(base + 1, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL backpressure_timeout: got no in_ack want in_ack"); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (ack_cnt !== base + 1) begin n_fail++; $display("FAIL backpressure_ack_count: got %0d want 1", ack_cnt - base); end
    n_cmp++; if (pack(act_q, rd) !== 64'h03_934D64_00000000) begin n_fail++; $display("FAIL backpressure_stream: got %h want %h", pack(act_q, rd), 64'h03_934D64_00000000); end
    rd = act_q.size();
    rs_valid = 1'b1; rs_last = 8'h93;
  endtask

  task automatic test_running_status();
    logic [63:0] want;
    int base;
    bit ok;
    apply_reset();
    want = RS ? 64'h05_934D644F64_0000 : 64'h06_934D64934F64_00;
    base = ack_cnt;
    send(1'b1, 4'd5, 2'd2, 4'd3);
    wait_ack(base + 1, 1'b0, ok);
    send(1'b1, 4'd7, 2'd2, 4'd3);
    wait_ack(base + 2, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL running_status_timeout: got %0d acks want 2", ack_cnt - base); end
    n_cmp++; if (pack(act_q, rd) !== want) begin n_fail++; $display("FAIL running_status_stream: got %h want %h", pack(act_q, rd), want); end
    rd = act_q.size();
    rs_valid = 1'b1; rs_last = 8'h93;
  endtask

  task automatic test_protocol_violation();
    int base;
    bit ok;
    base = ack_cnt;
    exp_q.delete();
    model(1'b0, 2, 1, 6);
    send(1'b0, 4'd2, 2'd1, 4'd6);
    @(posedge clk); #1;
    send(1'b1, 4'd9, 2'd3, 4'd11);
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ack !== 1'b1) begin n_fail++; $display("FAIL violation_done_cycle: got ack=%b want 1", bus.in_ack); end
    send(1'b1, 4'd1, 2'd0, 4'd12);
    wait_ack(base + 1, 1'b0, ok);
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (ack_cnt !== base + 1) begin n_fail++; $display("FAIL violation_ack_count: got %0d want 1", ack_cnt - base); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL violation_busy: got %b want 0", bus.busy); end
    n_cmp++; if (pack(act_q, rd) !== pack(exp_q, 0)) begin n_fail++; $display("FAIL violation_stream: got %h want %h", pack(act_q, rd), pack(exp_q, 0)); end
    rd = act_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_message();
    int base;
    bit ok;
    apply_reset();
    base = ack_cnt;
    send(1'b1, 4'd5, 2'd2, 4'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.tx_valid, bus.in_ack, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL midreset_outputs: got valid=%b ack=%b busy=%b want 0 0 0", bus.tx_valid, bus.in_ack, bus.busy); end
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (ack_cnt !== base) begin n_fail++; $display("FAIL midreset_no_ack: got %0d acks want 0", ack_cnt - base); end
    n_cmp++; if (pack(act_q, rd) !== 64'h01_93000000_000000) begin n_fail++; $display("FAIL midreset_partial: got %h want %h", pack(act_q, rd), 64'h01_93000000_000000); end
    rd = act_q.size();
    rs_valid = 1'b0;
    send(1'b1, 4'd5, 2'd2, 4'd3);
    wait_ack(base + 1, 1'b0, ok);
    n_cmp++; if (pack(act_q, rd) !== 64'h03_934D64_00000000) begin n_fail++; $display("FAIL midreset_resend: got %h want %h", pack(act_q, rd), 64'h03_934D64_00000000); end
    rd = act_q.size();
    rs_valid = 1'b1; rs_last = 8'h93;
  endtask

  task automatic test_random();
    int base;
    bit ok;
    bit on;
    int n, o, ch;
    for (int k = 0; k < 24; k++) begin
      on = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 15);
      o  = $urandom_range(0, 3);
      ch = $urandom_range(0, 3);
      exp_q.delete();
      model(on, n, o, ch);
      base = ack_cnt;
      send(on, 4'(n), 2'(o), 4'(ch));
      wait_ack(base + 1, 1'b1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL random%0d_timeout: got no in_ack want in_ack", k); end
      n_cmp++; if (pack(act_q, rd) !== pack(exp_q, 0)) begin n_fail++; $display("FAIL random%0d_stream: got %h want %h", k, pack(act_q, rd), pack(exp_q, 0)); end
      rd = act_q.size();
    end
    exp_q.delete();
  endtask

  initial begin
    bus.note_on_in = 1'b0;
    bus.note_in    = 4'd0;
    bus.octave_in  = 2'd0;
    bus.channel_in = 4'd0;
    bus.in_valid   = 1'b0;
    bus.tx_ready   = 1'b1;
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_running_status();
    test_protocol_violation();
    test_reset_mid_message();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
